// File: rtl/instr_encoder_pkg.sv
// Shared constants for the RV32I program loader: request kinds, opcodes,
// error codes, loader states and immediate range helpers.
package instr_encoder_pkg;

  localparam logic [2:0] KIND_R   = 3'd0;
  localparam logic [2:0] KIND_I   = 3'd1;
  localparam logic [2:0] KIND_LW  = 3'd2;
  localparam logic [2:0] KIND_SW  = 3'd3;
  localparam logic [2:0] KIND_BEQ = 3'd4;
  localparam logic [2:0] KIND_JAL = 3'd5;

  // Same opcode values the single-cycle control decoder matches on.
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_KIND  = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_OVF   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  // A 21-bit value fits N signed bits when all bits above N-1 copy the sign.
  function automatic logic fits_s12(input logic [20:0] imm);
    return (&imm[20:11]) | ~(|imm[20:11]);
  endfunction

  function automatic logic fits_s13(input logic [20:0] imm);
    return (&imm[20:12]) | ~(|imm[20:12]);
  endfunction

endpackage

// File: rtl/instr_encoder_rv_encode.sv
// Combinational RV32I field-to-word encoder for the loader's opcode subset,
// flagging unknown kinds and unencodable immediates.
module rv_encode
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (kind)
      KIND_R: begin
        word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      end
      KIND_I: begin
        word = {imm[11:0], rs1, funct3, rd, OP_I};
        // Shift forms keep shamt in imm[4:0] but own the upper funct7 field.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          word[31:25] = {1'b0, funct7b5, 5'b00000};
        end
        range_err = ~fits_s12(imm);
      end
      KIND_LW: begin
        word      = {imm[11:0], rs1, 3'b010, rd, OP_LW};
        range_err = ~fits_s12(imm);
      end
      KIND_SW: begin
        word      = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
        range_err = ~fits_s12(imm);
      end
      KIND_BEQ: begin
        word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BEQ};
        range_err = ~fits_s13(imm) | imm[0];
      end
      KIND_JAL: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        range_err = imm[0];
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Boot-time loader: accepts field-level requests, encodes them and writes
// the words sequentially into instruction memory, one every two cycles.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_kind,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic               in_funct7b5,
  input  logic [20:0]        in_imm,
  input  logic               in_last,
  output logic               imem_we,
  output logic [DEPTH_W-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err_code
);

  localparam logic [DEPTH_W-1:0] ADDR_MAX = '1;

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] addr_q,  addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               last_q,  last_d;
  logic [1:0]         err_q,   err_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        enc_range_err;

  rv_encode u_rv_encode (
    .kind      (in_kind),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .funct3    (in_funct3),
    .funct7b5  (in_funct7b5),
    .imm       (in_imm),
    .word      (enc_word),
    .illegal   (enc_illegal),
    .range_err (enc_range_err)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          addr_d  = '0;
          err_d   = ERR_NONE;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (enc_illegal) begin
            err_d   = ERR_KIND;
            state_d = S_ERROR;
          end else if (enc_range_err) begin
            err_d   = ERR_RANGE;
            state_d = S_ERROR;
          end else begin
            wdata_d = enc_word;
            last_d  = in_last;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // The address saturates at the top slot instead of wrapping to 0.
        if (last_q) begin
          state_d = S_DONE;
          if (addr_q != ADDR_MAX) addr_d = addr_q + DEPTH_W'(1);
        end else if (addr_q == ADDR_MAX) begin
          err_d   = ERR_OVF;
          state_d = S_ERROR;
        end else begin
          addr_d  = addr_q + DEPTH_W'(1);
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign imem_we    = (state_q == S_WRITE);
  assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err_code   = err_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule
